param_data_stack: RTL

- Parametrised successor to the fixed 16-bit memory stack and stack pointer pair in the CPU core.
- Holds a LIFO of WIDTH-bit words, DEPTH entries deep, with an internal pointer. Executes one stack-manipulation op per cycle: push, pop, dup, swap, over, pick, replace.
- Exposes top-of-stack and next-of-stack directly to the ALU S/T operand paths.
- Adds depth reporting, indexed pick and sticky overflow/underflow detection, none of which the current stack has.

---
 rtl/param_data_stack_pkg.sv | 22 ++
 rtl/param_data_stack_if.sv | 33 +++
 rtl/param_data_stack_legality.sv | 39 +++
 rtl/param_data_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/param_data_stack_pkg.sv
// Shared definitions for the parametrised data stack: op encoding and helpers.
package stack_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_PICK = 3'd6,
    OP_REPL = 3'd7
  } stackOp_t;

  // True for ops that leave one more entry on the stack than they found.
  function automatic logic grows(stackOp_t op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER) || (op == OP_PICK);
  endfunction

endpackage

// File: rtl/param_data_stack_if.sv
// Op/operand and status bundle between a stack client and the data stack.
interface param_data_stack_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int CNTW  = $clog2(DEPTH + 1)
);
  logic             i_valid;
  stackOp_t         i_op;
  logic [WIDTH-1:0] i_data;
  logic [IDXW-1:0]  i_index;
  logic             i_clear_err;
  logic [WIDTH-1:0] o_top;
  logic [WIDTH-1:0] o_next;
  logic [CNTW-1:0]  o_depth;
  logic             o_empty;
  logic             o_full;
  logic             o_overflow;
  logic             o_underflow;
  logic             o_fault;

  modport master (
    output i_valid, i_op, i_data, i_index, i_clear_err,
    input  o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow, o_fault
  );

  modport slave (
    input  i_valid, i_op, i_data, i_index, i_clear_err,
    output o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow, o_fault
  );
endinterface

// File: rtl/param_data_stack_legality.sv
// Decides whether a stack op can execute at the current depth. Purely
// combinational so other control logic can ask the same question.
module stack_legality_check
  import stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  stackOp_t        op,
  input  logic [CNTW-1:0] d,
  input  logic [IDXW-1:0] index,
  output logic            accept,
  output logic            overflow,
  output logic            underflow
);

  logic isFull;
  logic isEmpty;
  logic rawUnder;

  // Overflow wins over underflow, except DUT on an empty stack which can only underflow.
  always_comb begin
    isFull   = (d == CNTW'(DEPTH));
    isEmpty  = (d == '0);
    rawUnder = 1'b0;
    case (op)
      OP_POP, OP_DUP, OP_REPL: rawUnder = isEmpty;
      OP_SWAP, OP_OVER:        rawUnder = (d < CNTW'(2));
      OP_PICK:                 rawUnder = (CNTW'(index) >= d);
      default:                 rawUnder = 1'b0;
    endcase
    overflow  = grows(op) && isFull && !((op == OP_DUP) && isEmpty);
    underflow = rawUnder && !overflow;
    // NOP is trivially legal; the caller decides whether an op was issued.
    accept    = !overflow && !underflow;
  end

endmodule

// File: rtl/param_data_stack.sv
// LIFO of WIDTH-bit words with combinational top/next taps for the ALU,
// indexed pick, depth reporting and sticky overflow/underflow flags.
module param_data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input logic          i_clock,
  input logic          i_reset,
  param_data_stack_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNTW-1:0]  sp;
  logic [CNTW-1:0]  spNext;
  logic             ovfFlag;
  logic             undFlag;
  logic             faultPulse;

  stackOp_t         op;
  logic             issued;
  logic             legal;
  logic             ovf;
  logic             und;
  logic             doOp;
  logic             rejOvf;
  logic             rejUnd;

  logic [CNTW-1:0]  topPos;
  logic [CNTW-1:0]  nextPos;
  logic [CNTW-1:0]  pickPos;
  logic [WIDTH-1:0] topWord;
  logic [WIDTH-1:0] nextWord;
  logic [WIDTH-1:0] pickWord;

  logic             wrEnA;
  logic [IDXW-1:0]  wrAddrA;
  logic [WIDTH-1:0] wrDataA;
  logic             wrEnB;
  logic [IDXW-1:0]  wrAddrB;
  logic [WIDTH-1:0] wrDataB;

  // Positions past the array (e.g. sp-1 with sp==0) are clamped so reads
  // stay in range; callers mask such reads away.
  function automatic logic [IDXW-1:0] slot(input logic [CNTW-1:0] pos);
    return (pos < CNTW'(DEPTH)) ? IDXW'(pos) : '0;
  endfunction

  assign op      = bus.i_op;
  assign issued  = bus.i_valid && (op != OP_NOP);
  assign doOp    = issued && legal && !i_reset;
  assign rejOvf  = issued && ovf;
  assign rejUnd  = issued && und;

  stack_legality_check #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW),
    .CNTW  (CNTW)
  ) uLegal (
    .op        (op),
    .d         (sp),
    .index     (bus.i_index),
    .accept    (legal),
    .overflow  (ovf),
    .underflow (und)
  );

  // Combinational taps at depth 0, 1 and the requested pick depth.
  always_comb begin
    topPos   = sp - CNTW'(1);
    nextPos  = sp - CNTW'(2);
    pickPos  = sp - CNTW'(1) - CNTW'(bus.i_index);
    topWord  = (sp != '0)        ? mem[slot(topPos)]  : '0;
    nextWord = (sp >= CNTW'(2))  ? mem[slot(nextPos)] : '0;
    pickWord = mem[slot(pickPos)];
  end

  // Translate an accepted op into at most two array writes and the new pointer.
  always_comb begin
    wrEnA   = 1'b0;
    wrAddrA = slot(sp);
    wrDataA = bus.i_data;
    wrEnB   = 1'b0;
    wrAddrB = slot(nextPos);
    wrDataB = topWord;
    spNext  = sp;
    if (doOp) begin
      case (op)
        OP_PUSH: wrEnA = 1'b1;
        OP_DUP:  begin wrEnA = 1'b1; wrDataA = topWord;  end
        OP_OVER: begin wrEnA = 1'b1; wrDataA = nextWord; end
        OP_PICK: begin wrEnA = 1'b1; wrDataA = pickWord; end
        OP_REPL: begin wrEnA = 1'b1; wrAddrA = slot(topPos); end
        OP_SWAP: begin
          wrEnA   = 1'b1;
          wrAddrA = slot(topPos);
          wrDataA = nextWord;
          wrEnB   = 1'b1;
        end
        default: ;
      endcase
      if (grows(op)) begin
        spNext = sp + CNTW'(1);
      end else if (op == OP_POP) begin
        spNext = sp - CNTW'(1);
      end
    end
  end

  // Storage array; never reset, stale entries are hidden by sp.
  always_ff @(posedge i_clock) begin
    if (wrEnA) mem[wrAddrA] <= wrDataA;
    if (wrEnB) mem[wrAddrB] <= wrDataB;
  end

  // Pointer and error flags; a new fault beats a concurrent clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sp         <= '0;
      ovfFlag    <= 1'b0;
      undFlag    <= 1'b0;
      faultPulse <= 1'b0;
    end else begin
      sp         <= spNext;
      ovfFlag    <= (ovfFlag && !bus.i_clear_err) || rejOvf;
      undFlag    <= (undFlag && !bus.i_clear_err) || rejUnd;
      faultPulse <= rejOvf || rejUnd;
    end
  end

  assign bus.o_top       = topWord;
  assign bus.o_next      = nextWord;
  assign bus.o_depth     = sp;
  assign bus.o_empty     = (sp == '0);
  assign bus.o_full      = (sp == CNTW'(DEPTH));
  assign bus.o_overflow  = ovfFlag;
  assign bus.o_underflow = undFlag;
  assign bus.o_fault     = faultPulse;

endmodule
